// File: rtl/conv_encoder_k.sv
// conv_encoder_k: rate-1/2 feed-forward convolutional encoder.
// Two generator polynomials over a K-1 bit history, valid/ready handshake on
// both sides, and an automatic zero tail of K-1 symbols after each frame.
// Optional rate-2/3 puncturing of data symbols is built when the macro
// CONV_PUNCTURE_EN is defined; the default build has no puncturing.
module conv_encoder_k #(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = 7'b1111001,
  parameter logic [K-1:0] G1 = 7'b1011011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_bits,
  output logic [1:0] out_mask,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = $clog2(K);

  typedef enum logic {S_DATA, S_TAIL} state_e;

  state_e        state_q, state_d;
  logic [K-2:0]  sr_q, sr_d;       // sr_q[0] is the most recent past bit
  logic [CW-1:0] cnt_q, cnt_d;     // tail symbols still to be loaded
  logic          vld_q, vld_d;
  logic [1:0]    bits_q, bits_d;
  logic [1:0]    mask_q, mask_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
`ifdef CONV_PUNCTURE_EN
  logic          ph_q, ph_d;       // puncture phase, 1 = drop the G1 bit
`endif

  logic          drain;            // output register can take a new symbol
  logic          accept;
  logic          tail_emit;
  logic          load;
  logic          sym;
  logic          last_hs;
  logic [K-1:0]  tap;
  logic [1:0]    par;

  assign drain     = !vld_q || out_ready;
  assign in_ready  = (state_q == S_DATA) && drain;
  assign accept    = in_valid && in_ready;
  assign tail_emit = (state_q == S_TAIL) && (cnt_q != '0) && drain;
  assign load      = accept || tail_emit;
  assign sym       = (state_q == S_DATA) ? in_bit : 1'b0;
  assign last_hs   = vld_q && out_ready && last_q;

  // Tap vector: current symbol in the MSB, oldest history bit in the LSB.
  always_comb begin
    tap        = '0;
    tap[K-1]   = sym;
    for (int i = 0; i < K-1; i++) tap[K-2-i] = sr_q[i];
    par        = {^(G1 & tap), ^(G0 & tap)};
  end

  // Next-state: history shift, output register load/drain, frame FSM.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    bits_d  = bits_q;
    mask_d  = mask_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef CONV_PUNCTURE_EN
    ph_d    = ph_q;
`endif
    // A completed handshake empties the register unless refilled below.
    if (vld_q && out_ready) vld_d = 1'b0;
    if (load) begin
      sr_d   = {sr_q[K-3:0], sym};
      vld_d  = 1'b1;
      bits_d = par;
      mask_d = 2'b11;
      last_d = tail_emit && (cnt_q == CW'(1));
    end
    case (state_q)
      S_DATA: begin
        if (accept) begin
          busy_d = 1'b1;
`ifdef CONV_PUNCTURE_EN
          if (ph_q) begin
            mask_d    = 2'b01;
            bits_d[1] = 1'b0;
          end
          ph_d = ~ph_q;
`endif
          if (in_last) begin
            state_d = S_TAIL;
            cnt_d   = CW'(K-1);
          end
        end
      end
      S_TAIL: begin
        if (tail_emit) cnt_d = cnt_q - CW'(1);
        // History is all-zero here, so the next frame starts clean.
        if (last_hs) begin
          state_d = S_DATA;
          busy_d  = 1'b0;
`ifdef CONV_PUNCTURE_EN
          ph_d    = 1'b0;
`endif
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_DATA;
      sr_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      bits_q  <= 2'b00;
      mask_q  <= 2'b00;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CONV_PUNCTURE_EN
      ph_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      bits_q  <= bits_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef CONV_PUNCTURE_EN
      ph_q    <= ph_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign out_bits  = bits_q;
  assign out_mask  = mask_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder_k.sv
// Bench for conv_encoder_k: directed impulse/throughput/backpressure/reset
// steps plus random frames, checked against a convolution model of the code.
module tb_conv_encoder_k;

  localparam int         K  = 7;
  localparam logic [6:0] G0 = 7'b1111001;
  localparam logic [6:0] G1 = 7'b1011011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 0, in_ready, in_bit = 0, in_last = 0;
  logic out_valid, out_ready = 0, out_last, busy;
  logic [1:0] out_bits, out_mask;

  logic in_valid3 = 0, in_ready3, in_bit3 = 0, in_last3 = 0;
  logic out_valid3, out_ready3 = 1, out_last3, busy3;
  logic [1:0] out_bits3, out_mask3;

  always #5 clk = ~clk;

  conv_encoder_k #(.K(7), .G0(G0), .G1(G1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_mask(out_mask), .out_last(out_last), .busy(busy));

  conv_encoder_k #(.K(3), .G0(3'b111), .G1(3'b101)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_bit(in_bit3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_bits(out_bits3),
    .out_mask(out_mask3), .out_last(out_last3), .busy(busy3));

  typedef struct packed {
    logic [1:0] bits;
    logic [1:0] mask;
    logic       last;
  } sym_t;

  int   npass = 0, ntotal = 0;
  logic hist[$];          // data bits of the frame in progress
  sym_t expq[$];          // expected symbols in order
  sym_t obsq[$];          // handshaken symbols, for directed sequence checks
  logic acc, lhs, stall_prev = 1'b0;
  sym_t held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Parity of symbol j: sum over delays i of g(delay i) * x[j-i]; bits past
  // the end of the frame are the zero tail.
  function automatic logic par(input logic [6:0] g, input int j);
    logic p = 1'b0;
    for (int i = 0; i < K; i++) begin
      int idx = j - i;
      if (idx >= 0 && idx < hist.size()) p ^= g[K-1-i] & hist[idx];
    end
    return p;
  endfunction

  function automatic sym_t mk(input int j, input bit tail, input bit last);
    sym_t s;
    s.bits = {par(G1, j), par(G0, j)};
    s.mask = 2'b11;
    s.last = last;
`ifdef CONV_PUNCTURE_EN
    if (!tail && (j % 2 == 1)) begin
      s.mask    = 2'b01;
      s.bits[1] = 1'b0;
    end
`endif
    return s;
  endfunction

  task automatic model_accept(input logic b, input logic l);
    int j;
    hist.push_back(b);
    j = hist.size() - 1;
    expq.push_back(mk(j, 1'b0, 1'b0));
    if (l) begin
      for (int t = 1; t < K; t++) expq.push_back(mk(j + t, 1'b1, t == K-1));
      hist.delete();
    end
  endtask

  // One clock: sample at negedge, update model/scoreboard, return at posedge+1.
  task automatic tick();
    sym_t o, e;
    @(negedge clk);
    acc = in_valid && in_ready;
    lhs = 1'b0;
    if (out_valid && !out_ready) check("ready_gate", 32'(in_ready), 0);
    if (stall_prev)
      check("stall_hold", 32'({out_valid, out_bits, out_mask, out_last}),
            32'({1'b1, held.bits, held.mask, held.last}));
    if (acc) model_accept(in_bit, in_last);
    if (out_valid && out_ready) begin
      o = '{out_bits, out_mask, out_last};
      obsq.push_back(o);
      if (expq.size() == 0) check("extra_symbol", 32'(o), 32'hFFFF_FFFF);
      else begin
        e = expq.pop_front();
        check("symbol", 32'(o), 32'(e));
      end
      lhs = out_last;
    end
    stall_prev = out_valid && !out_ready;
    held = '{out_bits, out_mask, out_last};
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input int mode, input int cyc);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // mode 0: full rate, 1: out_ready pattern 1,0,0,1, 2: random both sides.
  task automatic send_frame(input int n, input logic [31:0] data, input int mode);
    int k = 0, cyc = 0, guard = 0;
    while (k < n && guard < 500) begin
      in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_bit   = in_valid ? data[n-1-k] : 1'($urandom);
      in_last  = in_valid ? (k == n-1) : 1'($urandom);
      set_ready(mode, cyc);
      tick();
      if (mode == 0) check("full_rate", 32'(acc), 1);
      if (acc) k++;
      cyc++; guard++;
    end
    check("data_accepted", k, n);
    in_valid = 1'b0;
    guard = 0;
    while (!lhs && guard < 200) begin
      in_bit  = 1'($urandom);
      in_last = 1'($urandom);
      check("tail_no_ready", 32'(in_ready), 0);
      check("tail_busy", 32'(busy), 1);
      set_ready(mode, cyc);
      tick();
      cyc++; guard++;
    end
    check("frame_end", 32'(lhs), 1);
    check("queue_drained", expq.size(), 0);
    check("busy_clear", 32'(busy), 0);
    check("ready_after_last", 32'(in_ready), 1);
  endtask

  task automatic check_impulse(input string tag);
    logic [6:0] e0, e1;
    e0 = 7'b1111001;
    e1 = 7'b1011011;
    check({tag, "_len"}, obsq.size(), 7);
    for (int t = 0; t < 7 && t < obsq.size(); t++)
      check(tag, 32'({obsq[t].bits, obsq[t].mask, obsq[t].last}),
            32'({e1[6-t], e0[6-t], 2'b11, 1'(t == 6)}));
  endtask

  initial begin
    logic [3:0] seq3;
    logic [1:0] exp3 [6];
    sym_t got3[$];

    // Reset state
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_bits",  32'(out_bits), 0);
    check("rst_mask",  32'(out_mask), 0);
    check("rst_last",  32'(out_last), 0);
    check("rst_busy",  32'(busy), 0);
    reset = 1'b1;
    tick();

    // Impulse response
    obsq.delete();
    send_frame(1, 32'h1, 0);
    check_impulse("impulse");

    // Throughput, then the next frame straight away
    send_frame(16, 32'hA5C3, 0);
    send_frame(5, 32'h16, 0);

    // Backpressure 1,0,0,1 through data and tail
    send_frame(10, 32'h2D9, 1);

    // Async reset in the middle of the tail
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_bits",  32'(out_bits), 0);
    check("mid_rst_last",  32'(out_last), 0);
    check("mid_rst_busy",  32'(busy), 0);
    hist.delete(); expq.delete(); stall_prev = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    obsq.delete();
    send_frame(1, 32'h1, 0);
    check_impulse("post_rst_impulse");

    // Random frames under random handshakes
    for (int f = 0; f < 6; f++) begin
      int n = $urandom_range(1, 20);
      send_frame(n, $urandom, 2);
    end

    // K=3 instance: 1,0,1,1 last
    seq3 = 4'b1011;
    exp3 = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
`ifdef CONV_PUNCTURE_EN
    exp3[3] = 2'b00;
`endif
    for (int i = 0; i < 4; i++) begin
      in_valid3 = 1'b1; in_bit3 = seq3[3-i]; in_last3 = (i == 3);
      @(negedge clk);
      check("k3_ready", 32'(in_ready3), 1);
      if (out_valid3) got3.push_back('{out_bits3, out_mask3, out_last3});
      @(posedge clk); #1;
    end
    in_valid3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid3) got3.push_back('{out_bits3, out_mask3, out_last3});
      @(posedge clk); #1;
    end
    check("k3_len", got3.size(), 6);
    for (int t = 0; t < 6 && t < got3.size(); t++) begin
      check("k3_bits", 32'(got3[t].bits), 32'(exp3[t]));
      check("k3_last", 32'(got3[t].last), 32'(t == 5));
    end
    check("k3_busy", 32'(busy3), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
